// File: rtl/parking_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg
//   Shared types and width helpers for the parking entrance-gate controller.
//   - state_e       : 3-bit state encoding, also driven out on state_o
//   - CODE_W        : width of the entry code
//   - ATT_W         : width of the wrong-attempt counter (MAX_ATTEMPTS 1..7)
//   - occ_width()   : width of an occupancy count for a given lot capacity
//   - tick_cnt_width(): width of the tick counter covering both timeouts
// ---------------------------------------------------------------------------
package parking_pkg;

  localparam int CODE_W = 4;
  localparam int ATT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_PASS  = 3'd1,
    ST_WRONG_PASS = 3'd2,
    ST_OPEN       = 3'd3,
    ST_STOP       = 3'd4
  } state_e;

  function automatic int occ_width(input int max_slots);
    return $clog2(max_slots + 1);
  endfunction

  function automatic int tick_cnt_width(input int wait_ticks, input int lock_ticks);
    return $clog2(((wait_ticks > lock_ticks) ? wait_ticks : lock_ticks) + 1);
  endfunction

endpackage

// File: rtl/parking_gate_fsm_tick_sync.sv
// ---------------------------------------------------------------------------
// tick_sync
//   Brings the clock divider's slow square wave into the clk domain and turns
//   each rising edge into a single-cycle tick.
//   Ports:
//     clk      in  system clock
//     reset    in  synchronous active-high reset
//     async_in in  slow square wave, asynchronous to clk
//     tick     out one-clk pulse, high 3 clk edges after async_in rises
//   Pipeline: sync1 -> sync2 (metastability guard) -> edge_q (previous
//   synchronized level); the tick itself is registered, so a rise sampled at
//   edge 1 shows up on tick after edge 3 and clears after edge 4. Falling
//   edges produce nothing.
// ---------------------------------------------------------------------------
module tick_sync
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q,  edge_d;
  logic tick_q,  tick_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
    tick_d  = sync2_q & ~edge_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/parking_gate_fsm.sv
// ---------------------------------------------------------------------------
// parking_gate_fsm
//   Entrance-gate controller: password-gated entry state machine, wrong-code
//   lockout, tick-based timeouts and lot occupancy tracking.
//   Ports:
//     clk, reset   in  system clock, synchronous active-high reset
//     slow_clk     in  divider square wave (~4 Hz), asynchronous level
//     sensor_in    in  car waiting at the entrance (level)
//     sensor_out   in  car has passed the gate (level)
//     car_leave    in  one-cycle pulse, a car left the lot
//     pass_code    in  entered code, qualified by pass_valid
//     pass_valid   in  one-cycle strobe
//     gate_open    out gate actuator (registered)
//     green_led    out entry granted (registered)
//     red_led      out refusal / wrong code / lockout (registered)
//     state_o      out state encoding, registered one cycle behind the FSM
//     occupancy    out cars in the lot (the occupancy register itself)
//     full         out occupancy == MAX_SLOTS
//   Build option: define BLINK_EN to make red_led blink on every tick while
//   in WRONG_PASS or STOP (phase starts on at state entry). Without it red_led
//   is steady in those states. The IDLE "lot full" refusal is always steady.
//
//   Code interface: pass_valid is a single-cycle strobe with no back-pressure;
//   the controller is always ready. The strobe and the compare result are
//   registered, so a strobe sampled at edge N acts on the FSM at edge N+1.
//   Strobes arriving in IDLE, OPEN or STOP are dropped.
// ---------------------------------------------------------------------------
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter logic [CODE_W-1:0] PASSWORD     = 4'b1011,
  parameter int                MAX_SLOTS    = 8,
  parameter int                MAX_ATTEMPTS = 3,
  parameter int                WAIT_TICKS   = 20,
  parameter int                LOCK_TICKS   = 40
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           slow_clk,
  input  logic                           sensor_in,
  input  logic                           sensor_out,
  input  logic                           car_leave,
  input  logic [CODE_W-1:0]              pass_code,
  input  logic                           pass_valid,
  output logic                           gate_open,
  output logic                           green_led,
  output logic                           red_led,
  output logic [2:0]                     state_o,
  output logic [$clog2(MAX_SLOTS+1)-1:0] occupancy,
  output logic                           full
);

  localparam int OCC_W = occ_width(MAX_SLOTS);
  localparam int CNT_W = tick_cnt_width(WAIT_TICKS, LOCK_TICKS);

  localparam logic [OCC_W-1:0] OCC_MAX   = OCC_W'(MAX_SLOTS);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_TICKS - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TICKS - 1);
  localparam logic [ATT_W-1:0] ATT_MAX   = ATT_W'(MAX_ATTEMPTS);

  logic tick;

  state_e           state_q, state_d;
  logic             pv_q, pv_d;
  logic             code_ok_q, code_ok_d;
  logic [ATT_W-1:0] att_q, att_d, att_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             gate_q, gate_d;
  logic             green_q, green_d;
  logic             red_q, red_d;
  logic [2:0]       state_o_q, state_o_d;

  logic entered;   // a transition is taken this cycle (self-loops included)
  logic occ_inc;   // car passed the gate this cycle
  logic occ_dec;   // car left and the lot is not already empty
  logic full_w;
  logic blink_on;

  tick_sync u_tick_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (slow_clk),
    .tick     (tick)
  );

  assign full_w = (occ_q == OCC_MAX);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    att_d     = att_q;
    cnt_d     = cnt_q;
    entered   = 1'b0;
    occ_inc   = 1'b0;
    pv_d      = pass_valid;
    code_ok_d = (pass_code == PASSWORD);
    att_inc   = att_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (sensor_in && !full_w) begin
          state_d = ST_WAIT_PASS;
          att_d   = '0;
          entered = 1'b1;
        end
      end

      ST_WAIT_PASS, ST_WRONG_PASS: begin
        // A strobe takes priority over a coincident timeout tick.
        if (pv_q) begin
          entered = 1'b1;
          if (code_ok_q) begin
            state_d = ST_OPEN;
          end else begin
            att_d   = att_inc;
            state_d = (att_inc == ATT_MAX) ? ST_STOP : ST_WRONG_PASS;
          end
        end else if (tick) begin
          if (cnt_q == WAIT_LAST) begin
            state_d = ST_IDLE;
            entered = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_OPEN: begin
        if (sensor_out) begin
          state_d = ST_IDLE;
          occ_inc = 1'b1;
          entered = 1'b1;
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (cnt_q == LOCK_LAST) begin
            state_d = ST_IDLE;
            att_d   = '0;
            entered = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        entered = 1'b1;
      end
    endcase

    // Every state entry (and every accepted strobe, which always transitions)
    // restarts the timeout count.
    if (entered) begin
      cnt_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Occupancy: an entry and a departure in the same cycle cancel out.
  // A departure from an empty lot is ignored; an entry into a full lot is
  // dropped.
  // -------------------------------------------------------------------------
  always_comb begin
    occ_dec = car_leave && (occ_q != '0);
    occ_d   = occ_q;
    if (occ_inc && occ_dec) begin
      occ_d = occ_q;
    end else if (occ_inc && !full_w) begin
      occ_d = occ_q + 1'b1;
    end else if (occ_dec) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Red LED blink phase
  // -------------------------------------------------------------------------
`ifdef BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (entered && (state_d == ST_WRONG_PASS || state_d == ST_STOP)) begin
      blink_d = 1'b1;
    end else if (tick && (state_q == ST_WRONG_PASS || state_q == ST_STOP)) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign blink_on = blink_q;
`else
  assign blink_on = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Output decode, registered one cycle behind the state register
  // -------------------------------------------------------------------------
  always_comb begin
    gate_d    = (state_q == ST_OPEN);
    green_d   = (state_q == ST_OPEN);
    state_o_d = state_q;
    red_d     = (((state_q == ST_WRONG_PASS) || (state_q == ST_STOP)) && blink_on) ||
                ((state_q == ST_IDLE) && full_w && sensor_in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pv_q      <= 1'b0;
      code_ok_q <= 1'b0;
      att_q     <= '0;
      cnt_q     <= '0;
      occ_q     <= '0;
      gate_q    <= 1'b0;
      green_q   <= 1'b0;
      red_q     <= 1'b0;
      state_o_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      pv_q      <= pv_d;
      code_ok_q <= code_ok_d;
      att_q     <= att_d;
      cnt_q     <= cnt_d;
      occ_q     <= occ_d;
      gate_q    <= gate_d;
      green_q   <= green_d;
      red_q     <= red_d;
      state_o_q <= state_o_d;
    end
  end

  assign gate_open = gate_q;
  assign green_led = green_q;
  assign red_led   = red_q;
  assign state_o   = state_o_q;
  assign occupancy = occ_q;
  assign full      = full_w;

endmodule
